// File: rtl/evolved_circuit_checker.sv
// Stimulus/response checker for two-input evolved latch circuits.
// Drives LFSR vectors, samples the synchronized response, scores it against a set/clear latch model.
module evolved_circuit_checker #(
  parameter int unsigned NUM_VECTORS   = 256,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dut_out,
  output logic [1:0]  dut_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] mismatch_count,
  output logic [15:0] compared_count,
  output logic [15:0] first_fail_idx
);

  localparam logic [7:0]  SEED        = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_CMP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [1:0]  dut_in_q, dut_in_d;
  logic [15:0] settle_q, settle_d;
  logic [15:0] idx_q, idx_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        exp_q, exp_d;
  logic        known_q, known_d;
  logic        pass_q, pass_d;
  logic [15:0] mis_q, mis_d;
  logic [15:0] cmp_q, cmp_d;
  logic [15:0] ffi_q, ffi_d;
  logic        nxt_known;
  logic        nxt_exp;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    dut_in_d  = dut_in_q;
    settle_d  = settle_q;
    idx_d     = idx_q;
    sync1_d   = dut_out;
    sync2_d   = sync1_q;
    exp_d     = exp_q;
    known_d   = known_q;
    pass_d    = pass_q;
    mis_d     = mis_q;
    cmp_d     = cmp_q;
    ffi_d     = ffi_q;
    nxt_known = known_q;
    nxt_exp   = exp_q;
    if (dut_in_q == 2'b11) begin
      nxt_known = 1'b1;
      nxt_exp   = 1'b1;
    end else if (dut_in_q == 2'b01) begin
      nxt_known = 1'b1;
      nxt_exp   = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_APPLY;
          lfsr_d   = SEED;
          dut_in_d = SEED[1:0];
          settle_d = '0;
          idx_d    = '0;
          known_d  = 1'b0;
          exp_d    = 1'b0;
          pass_d   = 1'b0;
          mis_d    = '0;
          cmp_d    = '0;
          ffi_d    = 16'hFFFF;
        end
      end
      S_APPLY: begin
        if (settle_q == SETTLE_LAST) state_d = S_CMP;
        else settle_d = settle_q + 16'd1;
      end
      S_CMP: begin
        known_d  = nxt_known;
        exp_d    = nxt_exp;
        settle_d = '0;
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        // Vectors before the first set/clear see an unknown DUT state.
        if (nxt_known) begin
          cmp_d = cmp_q + 16'd1;
          if (sync2_q != nxt_exp) begin
            if (mis_q != 16'hFFFF) mis_d = mis_q + 16'd1;
            if (mis_q == 16'd0) ffi_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          pass_d  = (mis_d == 16'd0);
        end else begin
          state_d  = S_APPLY;
          idx_d    = idx_q + 16'd1;
          dut_in_d = lfsr_d[1:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      dut_in_q <= 2'b00;
      settle_q <= '0;
      idx_q    <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      exp_q    <= 1'b0;
      known_q  <= 1'b0;
      pass_q   <= 1'b0;
      mis_q    <= '0;
      cmp_q    <= '0;
      ffi_q    <= 16'hFFFF;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      dut_in_q <= dut_in_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      exp_q    <= exp_d;
      known_q  <= known_d;
      pass_q   <= pass_d;
      mis_q    <= mis_d;
      cmp_q    <= cmp_d;
      ffi_q    <= ffi_d;
    end
  end

  assign dut_in         = dut_in_q;
  assign busy           = (state_q == S_APPLY) || (state_q == S_CMP);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign mismatch_count = mis_q;
  assign compared_count = cmp_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_evolved_circuit_checker.sv
// Bench for evolved_circuit_checker: random DUT behaviours scored by a vector-level model.
module tb_evolved_circuit_checker;

  localparam int NV  = 8;
  localparam int ST  = 4;
  localparam int PER = ST + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dut_out = 1'b0;
  logic [1:0]  dut_in;
  logic        busy, done, pass;
  logic [15:0] mis, cmpc, ffi;

  logic        start1 = 1'b0;
  logic        dut_out1 = 1'b0;
  logic [1:0]  dut_in1;
  logic        busy1, done1, pass1;
  logic [15:0] mis1, cmpc1, ffi1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  evolved_circuit_checker #(
    .NUM_VECTORS(NV), .SETTLE_CYCLES(ST), .LFSR_SEED(8'hA5)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .dut_out(dut_out),
    .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
    .mismatch_count(mis), .compared_count(cmpc), .first_fail_idx(ffi)
  );

  evolved_circuit_checker #(
    .NUM_VECTORS(1), .SETTLE_CYCLES(ST), .LFSR_SEED(8'h00)
  ) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .dut_out(dut_out1),
    .dut_in(dut_in1), .busy(busy1), .done(done1), .pass(pass1),
    .mismatch_count(mis1), .compared_count(cmpc1), .first_fail_idx(ffi1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ideal latch, 1 stuck-at-0, 2 stuck-at-1, 3 latch with per-vector flips
  task automatic run(input int mode, input logic [7:0] mask,
                     input bit glitch, input bit lat0);
    logic [1:0] vin[NV];
    logic       resp[NV];
    logic [7:0] l;
    logic       lat, known, ex;
    int         ecmp, emis, effi;
    l = 8'hA5;
    lat = lat0;
    for (int k = 0; k < NV; k++) begin
      vin[k] = l[1:0];
      l = lfsr_step(l);
      if (vin[k] == 2'b11) lat = 1'b1;
      else if (vin[k] == 2'b01) lat = 1'b0;
      case (mode)
        0:       resp[k] = lat;
        1:       resp[k] = 1'b0;
        2:       resp[k] = 1'b1;
        default: resp[k] = lat ^ mask[k];
      endcase
    end
    known = 1'b0;
    ex = 1'b0;
    ecmp = 0;
    emis = 0;
    effi = 32'hFFFF;
    for (int k = 0; k < NV; k++) begin
      if (vin[k] == 2'b11) begin known = 1'b1; ex = 1'b1; end
      if (vin[k] == 2'b01) begin known = 1'b1; ex = 1'b0; end
      if (known) begin
        ecmp++;
        if (resp[k] != ex) begin
          if (emis == 0) effi = k;
          emis++;
        end
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < NV * PER; c++) begin
      if (c % PER == 0) begin
        chk("dut_in", 32'(dut_in), 32'(vin[c / PER]));
        dut_out = resp[c / PER];
      end
      if (c == 0 || c == NV * PER - 1) chk("busy_run", 32'(busy), 1);
      if (c == 0) chk("done_early", 32'(done), 0);
      if (glitch && c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      tick();
    end
    chk("done", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 0);
    chk("pass", 32'(pass), 32'(emis == 0));
    chk("mismatch_count", 32'(mis), 32'(emis));
    chk("compared_count", 32'(cmpc), 32'(ecmp));
    chk("first_fail_idx", 32'(ffi), 32'(effi));
    chk("dut_in_hold", 32'(dut_in), 32'(vin[NV - 1]));
    tick();
    chk("done_pulse", 32'(done), 0);
    chk("results_hold", 32'(mis), 32'(emis));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    start1 = 1'b1;
    tick();
    tick();
    chk("rst_dut_in", 32'(dut_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_mis", 32'(mis), 0);
    chk("rst_cmp", 32'(cmpc), 0);
    chk("rst_ffi", 32'(ffi), 32'hFFFF);
    reset = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    tick();
    chk("start_in_reset", 32'(busy), 0);

    run(0, 8'h00, 1'b1, 1'b0);
    run(1, 8'h00, 1'b0, 1'b1);
    run(2, 8'h00, 1'b0, 1'b0);
    for (int r = 0; r < 10; r++)
      run(int'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_dut_in", 32'(dut_in), 0);
    chk("mid_rst_ffi", 32'(ffi), 32'hFFFF);
    chk("mid_rst_mis", 32'(mis), 0);
    chk("mid_rst_cmp", 32'(cmpc), 0);
    chk("mid_rst_pass", 32'(pass), 0);
    for (int c = 0; c < 2 * NV * PER; c++) begin
      if (done) chk("mid_rst_no_done", 32'(done), 0);
      tick();
    end
    chk("mid_rst_idle", 32'(busy), 0);

    dut_out1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("seed0_dut_in", 32'(dut_in1), 32'h1);
    for (int c = 0; c < PER; c++) begin
      chk("seed0_busy", 32'(busy1), 1);
      tick();
    end
    chk("seed0_done", 32'(done1), 1);
    chk("seed0_busy_end", 32'(busy1), 0);
    chk("seed0_cmp", 32'(cmpc1), 1);
    chk("seed0_pass", 32'(pass1), 1);
    chk("seed0_ffi", 32'(ffi1), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/evolved_circuit_checker.md
# evolved_circuit_checker

Synchronous stimulus/response harness for the two-input evolved latch circuits. It sits directly upstream and downstream of the circuit under test (DUT): it drives the DUT's 2-bit input, synchronizes and samples the DUT's 1-bit output, and checks it against a built-in golden model. The golden model is set on 11, clear on 01, hold on 00/10. Per-run pass/fail results are reported to the test controller.

## Interface
- `NUM_VECTORS`, 256: vectors per run, 1..65535.
- `SETTLE_CYCLES`, 4: cycles each vector is held before sampling; must be ≥3 to cover the synchronizer.
- `LFSR_SEED`, 8'hA5: stimulus LFSR seed; 0 is replaced by 8'h01.

- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  pulse; begins a run when idle.
- `dut_out`  in  1  asynchronous DUT output.
- `dut_in`  out  2  registered DUT stimulus.
- `busy`  out  1  high for the whole run.
- `done`  out  1  one-cycle pulse at run end.
- `pass`  out  1  1 when the last run had zero mismatches; valid from `done`.
- `mismatch_count`  out  16  mismatches in the last run, saturating at 16'hFFFF.
- `compared_count`  out  16  vectors actually compared.
- `first_fail_idx`  out  16  index of the first mismatching vector; 16'hFFFF if none.

## Operation
- States:
  - IDLE: on `start`, go to APPLY. `start` is ignored in all other states.
  - APPLY: hold `dut_in` for SETTLE_CYCLES cycles, then go to COMPARE.
  - COMPARE: lasts 1 cycle. Go to APPLY for the next vector, or to DONE after vector NUM_VECTORS-1.
  - DONE: lasts 1 cycle, then IDLE.
- Stimulus:
  - 8-bit Fibonacci LFSR, shifts left.
  - Feedback bit = b7^b5^b4^b3.
  - `dut_in` = lfsr[1:0].
  - LFSR loads the seed on the IDLE→APPLY transition and advances once per COMPARE.
- Synchronizer: `dut_out` passes through 2 flops. The sample is the synchronizer output in the COMPARE cycle.
- Golden model:
  - Holds `exp` and `known`; `known` clears at run start.
  - In COMPARE, first update the model: vector 11 sets exp=1, known=1; vector 01 sets exp=0, known=1; 00/10 leave it unchanged.
  - If `known` is then 1, compare sample against `exp` and increment `compared_count`.
  - If `known` is 0, the vector is skipped: no compare and no count. This covers the DUT's unknown power-up state.
- Mismatch handling: increment `mismatch_count` (saturating). If this is the first mismatch, latch the vector index into `first_fail_idx`.
- Results:
  - Counters and `first_fail_idx` clear at run start.
  - Results hold from `done` until the next `start`.
  - `pass` = (mismatch_count==0), registered when entering DONE.

## Timing
- Reset values: `dut_in`=00, `busy`=0, `done`=0, `pass`=0, counts=0, `first_fail_idx`=16'hFFFF, state IDLE, LFSR=seed, synchronizer=0.
- `start` sampled high in IDLE: next cycle `busy`=1 and `dut_in`=seed[1:0].
- Each vector occupies SETTLE_CYCLES+1 cycles; `dut_in` changes only on the cycle after COMPARE.
- Run length: `busy` is high for NUM_VECTORS×(SETTLE_CYCLES+1) cycles. `done` is high in the next cycle, with `busy`=0 that same cycle.
- `dut_in` stays at its last vector after the run; it is not forced to 00.
- `start` held continuously: a new run begins on the cycle after DONE.
- `reset` mid-run: all outputs return to their reset values on the next edge. No `done` pulse; partial results are discarded.
- `start` and `reset` in the same cycle: `reset` wins.

## Test plan
- Reset: assert `reset` 2 cycles → all outputs at reset values; `start` held during `reset` is ignored.
- Ideal latch DUT, NUM_VECTORS=8, SETTLE_CYCLES=4 → `dut_in` sequence 01,10,01,10,00,01,11,11 (LFSR A5,4A,95,2A,54,A9,53,A7). `busy` high 40 cycles, `done` at cycle 41; pass=1, mismatch_count=0, compared_count=8, first_fail_idx=FFFF.
- Stuck-at-0 DUT, same parameters → mismatch_count=2, first_fail_idx=6, pass=0.
- Stuck-at-1 DUT, same parameters → mismatch_count=6, first_fail_idx=0, pass=0.
- `start` pulsed again at cycle 10 of a run → ignored, run length unchanged. `reset` at cycle 20 → `busy`=0 next cycle, no `done` pulse, `first_fail_idx`=FFFF.
- LFSR_SEED=0, NUM_VECTORS=1 → first `dut_in`=01 (seed 01), compared_count=1, `done` after SETTLE_CYCLES+1 busy cycles.
